mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 47 ++++
 rtl/mem_lane_fmt.sv | 45 ++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : State encoding, byte-lane enables, response length and the
//            captured-request record shared by the memory arbiter files.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_if_busy = 2'd1;
    localparam state_t c_st_dm_busy = 2'd2;
    localparam state_t c_st_resp    = 2'd3;

    // Big-endian lanes: byte offset 0 lives in bits 31:24
    localparam logic [3:0] c_be_lane0 = 4'b1000;
    localparam logic [3:0] c_be_lane1 = 4'b0100;
    localparam logic [3:0] c_be_lane2 = 4'b0010;
    localparam logic [3:0] c_be_lane3 = 4'b0001;
    localparam logic [3:0] c_be_word  = 4'b1111;

    localparam logic [1:0] c_resp_len = 2'd1;

    typedef struct packed {
        logic        is_dm;
        logic        we;
        logic        is_byte;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [3:0] lane_be(input logic [1:0] offset);
        logic [3:0] be;
        case (offset)
            2'd0:    be = c_be_lane0;
            2'd1:    be = c_be_lane1;
            2'd2:    be = c_be_lane2;
            default: be = c_be_lane3;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_fmt
// Brief    : Combinational byte-lane formatter: enables, store replication,
//            load lane extraction with zero/sign extension.
// Revision : 1.0  initial release
// ============================================================================
module mem_lane_fmt
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic        i_is_byte,
    input  logic        i_signextend,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0] w_lane;

    always_comb begin
        case (i_offset)
            2'd0:    w_lane = i_rdata[31:24];
            2'd1:    w_lane = i_rdata[23:16];
            2'd2:    w_lane = i_rdata[15:8];
            default: w_lane = i_rdata[7:0];
        endcase
    end

    always_comb begin
        o_be    = i_is_byte ? lane_be(i_offset) : c_be_word;
        o_wdata = i_is_byte ? {4{i_wdata[7:0]}} : i_wdata;
        if (!i_is_byte) begin
            o_rdata = i_rdata;
        end else if (i_signextend) begin
            o_rdata = {{24{w_lane[7]}}, w_lane};
        end else begin
            o_rdata = {24'd0, w_lane};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester (fetch / data) arbiter onto one word memory port.
//            Build option MEM_ARB_RR_EN selects round-robin tie breaking,
//            otherwise data always beats fetch.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic        dm_signextend,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state_q, state_d;
    req_t        req_q, req_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic [1:0]  resp_cnt_q, resp_cnt_d;

    logic        w_grant_dm;
    logic        w_mem_active;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_fmt;

    mem_lane_fmt u_lane_fmt (
        .i_offset     (req_q.addr[1:0]),
        .i_is_byte    (req_q.is_byte),
        .i_signextend (req_q.sext),
        .i_wdata      (req_q.wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata_fmt)
    );

`ifdef MEM_ARB_RR_EN
    logic last_dm_q, last_dm_d;

    // On a tie the requester not served last wins; reset value favours DM
    assign w_grant_dm = dm_req && (!if_req || !last_dm_q);

    always_comb begin
        last_dm_d = last_dm_q;
        if (state_q == c_st_idle && (dm_req || if_req)) begin
            last_dm_d = w_grant_dm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm_q <= 1'b0;
        end else begin
            last_dm_q <= last_dm_d;
        end
    end
`else
    assign w_grant_dm = dm_req;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        resp_cnt_d = resp_cnt_q;
        case (state_q)
            c_st_idle: begin
                if (w_grant_dm) begin
                    req_d.is_dm   = 1'b1;
                    req_d.we      = dm_we;
                    req_d.is_byte = dm_byte;
                    req_d.sext    = dm_signextend;
                    req_d.addr    = dm_addr;
                    req_d.wdata   = dm_wdata;
                    state_d       = c_st_dm_busy;
                end else if (if_req) begin
                    req_d.is_dm   = 1'b0;
                    req_d.we      = 1'b0;
                    req_d.is_byte = 1'b0;
                    req_d.sext    = 1'b0;
                    req_d.addr    = if_addr;
                    req_d.wdata   = 32'd0;
                    state_d       = c_st_if_busy;
                end
            end
            c_st_if_busy, c_st_dm_busy: begin
                if (mem_ack) begin
                    state_d    = c_st_resp;
                    resp_cnt_d = 2'd0;
                    if (req_q.is_dm) begin
                        dm_rdata_d = req_q.we ? 32'd0 : w_rdata_fmt;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            c_st_resp: begin
                if (resp_cnt_q == c_resp_len - 2'd1) begin
                    state_d = c_st_idle;
                end else begin
                    resp_cnt_d = resp_cnt_q + 2'd1;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_st_idle;
            req_q      <= '0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
            resp_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    // Memory-side outputs are forced to zero outside the busy states
    assign w_mem_active = (state_q == c_st_if_busy) || (state_q == c_st_dm_busy);
    assign mem_req      = w_mem_active;
    assign mem_we       = w_mem_active && req_q.we;
    assign mem_be       = w_mem_active ? w_be : 4'd0;
    assign mem_addr     = w_mem_active ? {req_q.addr[31:2], 2'b00} : 32'd0;
    assign mem_wdata    = (w_mem_active && req_q.we) ? w_wdata : 32'd0;

    assign if_ack   = (state_q == c_st_resp) && !req_q.is_dm;
    assign dm_ack   = (state_q == c_st_resp) && req_q.is_dm;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;
    assign busy     = (state_q != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed and randomized bench for mem_arbiter with a
//            transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic        dm_byte;
    logic        dm_signextend;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_ack        (if_ack),
        .if_rdata      (if_rdata),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_byte       (dm_byte),
        .dm_signextend (dm_signextend),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_ack        (dm_ack),
        .dm_rdata      (dm_rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // phase: 0 = waiting for a request, 1 = memory access open, 2 = answering
    int          m_phase;
    logic        m_dm, m_we, m_byte, m_sext;
    logic [1:0]  m_off;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic        m_last_dm, m_if_done, m_dm_done;

    function automatic logic [31:0] load_value(input logic [31:0] word, input logic bt,
                                               input logic sx, input logic [1:0] off);
        logic [31:0] sh;
        logic [7:0]  b;
        if (!bt) return word;
        sh = word >> (8 * (3 - int'(off)));
        b  = sh[7:0];
        return sx ? {{24{b[7]}}, b} : {24'd0, b};
    endfunction

    function automatic logic pick_dm(input logic dq, input logic iq, input logic last_dm);
`ifdef MEM_ARB_RR_EN
        return dq && (!iq || !last_dm);
`else
        return dq && (iq || !last_dm || last_dm);
`endif
    endfunction

    always @(posedge clk) begin
        m_if_done <= 1'b0;
        m_dm_done <= 1'b0;
        if (rst) begin
            m_phase    <= 0;
            m_dm       <= 1'b0;
            m_if_rdata <= 32'd0;
            m_dm_rdata <= 32'd0;
            m_last_dm  <= 1'b0;
        end else if (m_phase == 0) begin
            if (pick_dm(dm_req, if_req, m_last_dm)) begin
                m_phase <= 1;
                m_dm    <= 1'b1;
                m_we    <= dm_we;
                m_byte  <= dm_byte;
                m_sext  <= dm_signextend;
                m_off   <= dm_addr[1:0];
                m_addr  <= dm_addr & 32'hFFFF_FFFC;
                m_be    <= dm_byte ? (4'b1000 >> dm_addr[1:0]) : 4'hF;
                m_wdata <= !dm_we ? 32'd0 : (dm_byte ? {4{dm_wdata[7:0]}} : dm_wdata);
            end else if (if_req) begin
                m_phase <= 1;
                m_dm    <= 1'b0;
                m_we    <= 1'b0;
                m_byte  <= 1'b0;
                m_sext  <= 1'b0;
                m_off   <= 2'd0;
                m_addr  <= if_addr & 32'hFFFF_FFFC;
                m_be    <= 4'hF;
                m_wdata <= 32'd0;
            end
        end else if (m_phase == 1) begin
            if (mem_ack) begin
                m_phase <= 2;
                if (m_dm) m_dm_rdata <= m_we ? 32'd0 : load_value(mem_rdata, m_byte, m_sext, m_off);
                else      m_if_rdata <= mem_rdata;
            end
        end else begin
            m_phase   <= 0;
            m_last_dm <= m_dm;
            m_if_done <= !m_dm;
            m_dm_done <= m_dm;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",      busy,      m_phase != 0);
            chk("mem_req",   mem_req,   m_phase == 1);
            chk("mem_we",    mem_we,    (m_phase == 1) && m_we);
            chk("mem_be",    mem_be,    (m_phase == 1) ? m_be : 4'd0);
            chk("mem_addr",  mem_addr,  (m_phase == 1) ? m_addr : 32'd0);
            chk("mem_wdata", mem_wdata, (m_phase == 1) ? m_wdata : 32'd0);
            chk("if_ack",    if_ack,    (m_phase == 2) && !m_dm);
            chk("dm_ack",    dm_ack,    (m_phase == 2) && m_dm);
            chk("ack_excl",  if_ack && dm_ack, 1'b0);
            if (m_phase == 2 && !m_dm) chk("if_rdata", if_rdata, m_if_rdata);
            if (m_phase == 2 && m_dm)  chk("dm_rdata", dm_rdata, m_dm_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        if_req = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_byte = 0; dm_signextend = 0; dm_addr = 0; dm_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    // From an idle cycle: one data access with literal expectations
    task automatic dm_one(input logic we, input logic bt, input logic sx, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        dm_req = 1; dm_we = we; dm_byte = bt; dm_signextend = sx; dm_addr = addr; dm_wdata = wd;
        step();
        chk("dm_mem_be",   mem_be,   ebe);
        chk("dm_mem_we",   mem_we,   we);
        chk("dm_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        if (we) chk("dm_mem_wdata", mem_wdata, ewd);
        mem_ack = 1; mem_rdata = rd;
        step();
        mem_ack = 0; dm_req = 0;
        chk("dm_ack",   dm_ack,   1);
        chk("dm_rdata", dm_rdata, erd);
        step();
    endtask

    // From an idle cycle: expect a grant to exp_addr, finish in the answer cycle
    task automatic serve(input string name, input logic [31:0] exp_addr, input logic exp_dm);
        step();
        chk(name, mem_addr, exp_addr);
        mem_ack = 1; mem_rdata = $urandom;
        step();
        mem_ack = 0;
        chk({name, "_ack"}, exp_dm ? dm_ack : if_ack, 1);
    endtask

    logic        rr_second_dm;
    logic [31:0] rr_second_addr;
    int          ack_cnt;

    initial begin
        clr();
        rst = 1;
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy",    busy,    0);
        chk("rst_if_ack",  if_ack,  0);
        chk("rst_dm_ack",  dm_ack,  0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        cmp_en = 1;
        rst = 0;
        step();

        // word fetch, minimum latency
        if_req = 1; if_addr = 32'h100;
        step();
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_addr",    mem_addr, 32'h100);
        chk("fetch_be",      mem_be, 4'hF);
        chk("fetch_we",      mem_we, 0);
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 0; if_req = 0;
        chk("fetch_ack",   if_ack, 1);
        chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        step();
        chk("fetch_ack_once", if_ack, 0);

        dm_one(0, 1, 1, 32'h203, 32'h0,  32'h1234_56F0, 4'b0001, 32'h0, 32'hFFFF_FFF0);
        dm_one(0, 1, 0, 32'h203, 32'h0,  32'h1234_56F0, 4'b0001, 32'h0, 32'h0000_00F0);
        dm_one(1, 1, 0, 32'h201, 32'hAB, 32'h5555_5555, 4'b0100, 32'hABAB_ABAB, 32'h0);
        dm_one(0, 1, 0, 32'h200, 32'h0,  32'h8899_AABB, 4'b1000, 32'h0, 32'h0000_0088);
        dm_one(0, 0, 1, 32'h302, 32'h0,  32'h8765_4321, 4'hF,    32'h0, 32'h8765_4321);
        dm_one(1, 0, 0, 32'h404, 32'hCAFE_F00D, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0);

        // simultaneous requests: DM first, then IF
        if_req = 1; if_addr = 32'h400;
        dm_req = 1; dm_we = 0; dm_byte = 0; dm_addr = 32'h500;
        serve("tie_first", 32'h500, 1);
        dm_req = 0;
        step();
        serve("tie_second", 32'h400, 0);
        dm_req = 1;
        step();
`ifdef MEM_ARB_RR_EN
        rr_second_addr = 32'h400; rr_second_dm = 0;
`else
        rr_second_addr = 32'h500; rr_second_dm = 1;
`endif
        serve("held_first", 32'h500, 1);
        step();
        serve("held_second", rr_second_addr, rr_second_dm);
        step();
        serve("held_third", 32'h500, 1);
        if_req = 0; dm_req = 0;
        step();

        // reset aborts a data access; a late mem_ack is ignored
        dm_req = 1; dm_we = 0; dm_byte = 0; dm_addr = 32'h900;
        step();
        chk("abort_busy_before", mem_req, 1);
        rst = 1;
        step();
        rst = 0; dm_req = 0; mem_ack = 1; mem_rdata = 32'h1111_2222;
        chk("abort_mem_req", mem_req, 0);
        chk("abort_busy",    busy,    0);
        chk("abort_dm_ack",  dm_ack,  0);
        step();
        mem_ack = 0;
        chk("abort_no_ack",   dm_ack, 0);
        chk("abort_no_busy",  busy,   0);
        chk("abort_rdata",    dm_rdata, 0);
        step();

        // memory answers after five wait cycles
        if_req = 1; if_addr = 32'h7FC;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("delay_mem_req",  mem_req,  1);
            chk("delay_mem_addr", mem_addr, 32'h7FC);
            chk("delay_no_ack",   if_ack,   0);
            step();
        end
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 0; if_req = 0;
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ack_cnt += int'(if_ack);
            step();
        end
        chk("delay_ack_count", ack_cnt, 1);

        // randomized traffic
        clr();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom % 200 == 0);
            if (if_req && m_if_done) if_req = 0;
            if (!if_req && ($urandom % 3 == 0)) begin
                if_req = 1; if_addr = $urandom;
            end
            if (dm_req && m_dm_done) dm_req = 0;
            if (!dm_req && ($urandom % 3 == 0)) begin
                dm_req = 1; dm_we = $urandom % 2; dm_byte = $urandom % 2;
                dm_signextend = $urandom % 2; dm_addr = $urandom; dm_wdata = $urandom;
            end
            mem_ack   = (m_phase == 1) ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
            mem_rdata = $urandom;
            step();
        end
        clr();
        rst = 0;
        step(); step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
